// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a small instruction queue between the PC
// generator and decode. Up to MAX_OUTSTANDING fetches may be in flight on a
// split address/data bus. Responses come back in order and are matched to
// their PC through a small PC tag FIFO. Exception, eret and taken branches
// flush the queue. Responses to requests issued before the flush are counted
// off and dropped.
//
// Optional feature macro: IF_ADEL_CHECK_EN
//   defined   : a misaligned fetch_pc is never put on the bus. Once the bus is
//               idle and the queue has room, an AdEL entry (exccode 5'h04,
//               inst 0) is queued and fetching halts until the next flush.
//   undefined : no alignment check. A misaligned fetch_pc is issued unchanged
//               and de_exccode is always 5'h00.
//
// Parameters
//   DEPTH           instruction queue entries (power of two, >= 2)
//   MAX_OUTSTANDING accepted-but-unanswered requests allowed (1..DEPTH)
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_req/addr     fetch request valid / address (addr is 0 when idle)
//   inst_addr_ok      request accepted this cycle
//   inst_data_ok      one in-order response this cycle, data on inst_rdata
//   de_valid/ready    head-of-queue handshake toward decode
//   de_pc/inst/exccode head entry fields, forced to 0 while de_valid=0
//   exception/_entry  flush to the handler address (highest priority)
//   eret/epc          flush to the return address
//   redirect/_pc      flush to the branch target (lowest priority)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        de_ready,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_inst,
  output logic [4:0]  de_exccode,
  input  logic        exception,
  input  logic [31:0] exception_entry,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUM_W = CNT_W + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [OS_W-1:0]  r_outstanding;
  logic [OS_W-1:0]  r_discard;
  logic [TAG_W-1:0] r_tag_wr;
  logic [TAG_W-1:0] r_tag_rd;

  // Queue and tag storage. These are never reset: the read side is
  // qualified by r_count and by the tag pointers.
  logic [31:0]      r_q_pc   [DEPTH];
  logic [31:0]      r_q_inst [DEPTH];
  logic [31:0]      r_tag_pc [MAX_OUTSTANDING];

`ifdef IF_ADEL_CHECK_EN
  logic             r_halt;
  logic             r_q_adel [DEPTH];
  logic             w_misalign;
`endif

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic             w_flush;
  logic [31:0]      w_new_pc;
  logic             w_issue_ok;
  logic             w_credit_ok;
  logic [SUM_W-1:0] w_credit_sum;
  logic             w_accept;
  logic             w_resp;
  logic             w_drop;
  logic             w_resp_push;
  logic             w_adel_push;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_push_pc;
  logic [31:0]      w_push_inst;
  logic [OS_W-1:0]  w_outstanding_next;
  logic [CNT_W-1:0] w_count_next;

  assign w_flush = exception | eret | redirect;

  always_comb begin
    w_new_pc = redirect_pc;
    if (exception) begin
      w_new_pc = exception_entry;
    end else if (eret) begin
      w_new_pc = epc;
    end
  end

`ifdef IF_ADEL_CHECK_EN
  assign w_misalign = (r_fetch_pc[1:0] != 2'b00);
  assign w_issue_ok = !r_halt && !w_misalign;
  // The AdEL entry waits until every older response has landed so that it
  // takes its place in program order. A response in the same cycle would be
  // a bus protocol error, but it is kept off the single push port anyway.
  assign w_adel_push = w_misalign && !r_halt && !w_flush &&
                       (r_outstanding == '0) &&
                       (r_count < CNT_W'(DEPTH)) && !inst_data_ok;
`else
  assign w_issue_ok  = 1'b1;
  assign w_adel_push = 1'b0;
`endif

  // Credit rule: every request in flight already owns a queue slot, so a
  // response can always be pushed without a full check.
  assign w_credit_sum = SUM_W'(r_count) + SUM_W'(r_outstanding);
  assign w_credit_ok  = (w_credit_sum < SUM_W'(DEPTH)) &&
                        (r_outstanding < OS_W'(MAX_OUTSTANDING));

  // rst_n gates the request so that the bus sees inst_req=0 while reset is
  // held and a request at RESET_PC as soon as it is released.
  assign inst_req  = rst_n && w_issue_ok && !w_flush && w_credit_ok;
  assign inst_addr = inst_req ? r_fetch_pc : 32'h0;

  assign w_accept    = inst_req && inst_addr_ok;
  assign w_resp      = inst_data_ok;
  assign w_drop      = w_resp && (r_discard != '0);
  assign w_resp_push = w_resp && !w_drop;
  assign w_push      = w_resp_push || w_adel_push;
  assign w_pop       = de_valid && de_ready && !w_flush;

  assign w_push_pc   = w_adel_push ? r_fetch_pc : r_tag_pc[r_tag_rd];
  assign w_push_inst = w_adel_push ? 32'h0 : inst_rdata;

  // Accept and response in the same cycle cancel out. A flush starts its
  // discard count from this value: every request still in flight after this
  // edge is stale. Any response taken this cycle is already subtracted here.
  assign w_outstanding_next = r_outstanding + OS_W'(w_accept) - OS_W'(w_resp);
  assign w_count_next       = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    if (p == TAG_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + TAG_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
`ifdef IF_ADEL_CHECK_EN
      r_halt        <= 1'b0;
`endif
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_flush) begin
        r_fetch_pc <= w_new_pc;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_discard  <= w_outstanding_next;
        // Tags of stale requests are thrown away. Their responses are
        // absorbed by r_discard and never read the tag FIFO.
        r_tag_wr   <= '0;
        r_tag_rd   <= '0;
`ifdef IF_ADEL_CHECK_EN
        r_halt     <= 1'b0;
`endif
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_tag_wr   <= tag_inc(r_tag_wr);
        end
        if (w_resp_push) begin
          r_tag_rd <= tag_inc(r_tag_rd);
        end
        if (w_drop) begin
          r_discard <= r_discard - OS_W'(1);
        end
        if (w_push) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= w_count_next;
`ifdef IF_ADEL_CHECK_EN
        if (w_adel_push) begin
          r_halt <= 1'b1;
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage writes
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_pc[r_tail]   <= w_push_pc;
      r_q_inst[r_tail] <= w_push_inst;
`ifdef IF_ADEL_CHECK_EN
      r_q_adel[r_tail] <= w_adel_push;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Decode-side outputs (zeroed when the queue is empty)
  // -------------------------------------------------------------------------
  assign de_valid = (r_count != '0);
  assign de_pc    = de_valid ? r_q_pc[r_head]   : 32'h0;
  assign de_inst  = de_valid ? r_q_inst[r_head] : 32'h0;

`ifdef IF_ADEL_CHECK_EN
  assign de_exccode = (de_valid && r_q_adel[r_head]) ? 5'h04 : 5'h00;
`else
  assign de_exccode = 5'h00;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        de_ready;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_inst;
  logic [4:0]  de_exccode;
  logic        exception;
  logic [31:0] exception_entry;
  logic        eret;
  logic [31:0] epc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH          (4),
    .MAX_OUTSTANDING(2),
    .RESET_PC       (RESET_PC)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .de_ready       (de_ready),
    .de_valid       (de_valid),
    .de_pc          (de_pc),
    .de_inst        (de_inst),
    .de_exccode     (de_exccode),
    .exception      (exception),
    .exception_entry(exception_entry),
    .eret           (eret),
    .epc            (epc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
  } exp_t;

  exp_t        exp_q[$];      // scoreboard: entries decode should see, in order
  logic [31:0] bus_q[$];      // bus model: addresses awaiting a response
  logic [31:0] exp_fetch_pc;  // model of the next fetch address
  int          n_total;
  int          n_bad;
  int          n_acc;         // accepts since the last flush
  int          n_pop;
  bit          rsp_en;

  // Instruction memory contents seen by the bus model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %-18s got=%08h want=%08h @%0t", tag, got, want, $time);
    end else begin
      $display("  ok %-18s val=%08h @%0t", tag, got, $time);
    end
  endtask

  // One clock cycle. The monitor runs on the falling edge, when every input
  // for this cycle is stable. It predicts the handshakes of the coming rising
  // edge and updates the scoreboard and the bus model. The new bus response
  // is driven just after the rising edge.
  task automatic step();
    logic        acc;
    logic        rsp;
    logic        pop;
    logic        flush;
    logic [31:0] npc;
    exp_t        e;
    @(negedge clk);
    flush = exception | eret | redirect;
    acc   = inst_req & inst_addr_ok;
    rsp   = inst_data_ok;
    pop   = de_valid & de_ready & !flush;
    if (flush) check("req_in_flush", 32'(inst_req), 32'd0);
    if (acc)   check("req_addr", inst_addr, exp_fetch_pc);
    if (!de_valid) check("gate_zero", de_pc | de_inst | 32'(de_exccode), 32'd0);
    if (pop) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("de_pc", de_pc, e.pc);
        check("de_inst", de_inst, e.inst);
        check("de_exccode", 32'(de_exccode), 32'(e.exc));
      end
      n_pop++;
    end
    if (flush) begin
      npc = exception ? exception_entry : (eret ? epc : redirect_pc);
      exp_q.delete();
      exp_fetch_pc = npc;
      n_acc = 0;
`ifdef IF_ADEL_CHECK_EN
      if (npc[1:0] != 2'b00) begin
        e.pc = npc; e.inst = 32'h0; e.exc = 5'h04;
        exp_q.push_back(e);
      end
`endif
    end else if (acc) begin
      e.pc = exp_fetch_pc; e.inst = mem_word(exp_fetch_pc); e.exc = 5'h00;
      exp_q.push_back(e);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      n_acc++;
    end
    if (acc) bus_q.push_back(inst_addr);
    if (rsp && bus_q.size() != 0) void'(bus_q.pop_front());
    @(posedge clk);
    #1;
    if (rsp_en && bus_q.size() != 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(bus_q[0]);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] want);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (inst_req) begin
        check(tag, inst_addr, want);
        return;
      end
      step();
    end
    check({tag, "_seen"}, 32'(inst_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (de_valid) return;
      step();
    end
    check(tag, 32'(de_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    de_ready = 1'b0; exception = 1'b0; exception_entry = 32'h0; eret = 1'b0;
    epc = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
    rsp_en = 1'b1; exp_fetch_pc = RESET_PC;
    n_total = 0; n_bad = 0; n_acc = 0; n_pop = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    check("rst_de_valid", 32'(de_valid), 32'd0);
    check("rst_de_pc", de_pc, 32'd0);
    check("rst_de_inst", de_inst, 32'd0);
    check("rst_de_exccode", 32'(de_exccode), 32'd0);

    // Streaming at full rate
    inst_addr_ok = 1'b1; de_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    #1;
    check("first_req", 32'(inst_req), 32'd1);
    check("first_addr", inst_addr, RESET_PC);
    repeat (4) step();
    p0 = n_pop;
    repeat (16) step();
    check("stream_pops", 32'(n_pop - p0), 32'd16);

    // Backpressure: restart at RESET_PC with decode stalled
    de_ready = 1'b0; redirect = 1'b1; redirect_pc = RESET_PC;
    step();
    redirect = 1'b0;
    repeat (12) step();
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_req_low", 32'(inst_req), 32'd0);
    check("bp_valid", 32'(de_valid), 32'd1);
    check("bp_head_pc", de_pc, RESET_PC);
    de_ready = 1'b1;
    repeat (8) step();

    // Redirect with two requests in flight
    rsp_en = 1'b0;
    repeat (6) step();
    check("max_outstanding", 32'(bus_q.size()), 32'd2);
    rsp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect = 1'b0;
    wait_req("redir_addr", 32'h8000_0100);
    wait_valid("redir_valid");
    check("redir_first_pc", de_pc, 32'h8000_0100);
    check("redir_first_inst", de_inst, mem_word(32'h8000_0100));
    repeat (4) step();

    // Flush priority
    exception = 1'b1; exception_entry = 32'hbfc0_0380;
    redirect = 1'b1; redirect_pc = 32'h1234_5678;
    step();
    exception = 1'b0; redirect = 1'b0;
    wait_req("exc_prio_addr", 32'hbfc0_0380);
    repeat (4) step();
    eret = 1'b1; epc = 32'h8000_0040;
    step();
    eret = 1'b0;
    wait_req("eret_addr", 32'h8000_0040);
    repeat (4) step();
    eret = 1'b1; epc = 32'h8000_0080;
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    eret = 1'b0; redirect = 1'b0;
    wait_req("eret_prio_addr", 32'h8000_0080);
    repeat (4) step();

    // Misaligned target
`ifdef IF_ADEL_CHECK_EN
    de_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
    wait_valid("adel_valid");
    check("adel_pc", de_pc, 32'h8000_0102);
    check("adel_inst", de_inst, 32'h0);
    check("adel_exccode", 32'(de_exccode), 32'h04);
    repeat (6) step();
    check("adel_no_accept", 32'(n_acc), 32'd0);
    check("adel_req_low", 32'(inst_req), 32'd0);
    de_ready = 1'b1;
    repeat (4) step();
    check("adel_halt_req", 32'(inst_req), 32'd0);
    check("adel_halt_valid", 32'(de_valid), 32'd0);
`else
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
    wait_req("misalign_addr", 32'h8000_0102);
    repeat (6) step();
`endif
    exception = 1'b1; exception_entry = 32'hbfc0_0380;
    step();
    exception = 1'b0;
    wait_req("resume_addr", 32'hbfc0_0380);
    repeat (6) step();

    // Asynchronous reset mid-burst
    check("pre_rst_valid", 32'(de_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_de_valid", 32'(de_valid), 32'd0);
    check("arst_inst_req", 32'(inst_req), 32'd0);
    check("arst_de_pc", de_pc, 32'd0);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    bus_q.delete(); exp_q.delete(); exp_fetch_pc = RESET_PC;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
